// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width
// and the bit-counter width derivation.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder composed of two half-adder stages and an OR for the carry.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO
);

    logic ha0_sum_s;
    logic ha0_carry_s;
    logic ha1_carry_s;

    assign ha0_sum_s   = A ^ B;
    assign ha0_carry_s = A & B;
    assign S           = ha0_sum_s ^ CI;
    assign ha1_carry_s = ha0_sum_s & CI;
    assign CO          = ha0_carry_s | ha1_carry_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per cycle through a single full adder,
// sum shifted in MSB-first so it lands LSB-aligned after WIDTH cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_r;
    state_e           state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             shift_s;
    logic             last_s;
    logic             fa_sum_s;
    logic             fa_co_s;

    full_adder u_full_adder (
        .A  (a_r[0]),
        .B  (b_r[0]),
        .CI (carry_r),
        .S  (fa_sum_s),
        .CO (fa_co_s)
    );

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (START) begin
                    load_s       = 1'b1;
                    state_next_s = ADD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADD: begin
                shift_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    last_s       = 1'b1;
                    state_next_s = FIN;
                end else begin
                    state_next_s = ADD;
                end
            end
            FIN: begin
                // A request in the result cycle starts the next addition directly.
                if (START) begin
                    load_s       = 1'b1;
                    state_next_s = ADD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand shift registers, carry flop, bit counter and serial sum.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            carry_r <= 1'b0;
        end else if (load_s) begin
            a_r     <= A;
            b_r     <= B;
            cnt_r   <= {CNT_W{1'b0}};
            carry_r <= CIN;
        end else if (shift_s) begin
            a_r     <= {1'b0, a_r[WIDTH-1:1]};
            b_r     <= {1'b0, b_r[WIDTH-1:1]};
            s_r     <= {fa_sum_s, s_r[WIDTH-1:1]};
            cnt_r   <= cnt_r + CNT_W'(1);
            carry_r <= fa_co_s;
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            s_r     <= s_r;
            cnt_r   <= cnt_r;
            carry_r <= carry_r;
        end
    end

    // Result flags captured on the MSB step; carry_r then holds the carry into the MSB.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_s) begin
            cout_r <= fa_co_s;
            ovf_r  <= carry_r ^ fa_co_s;
        end else begin
            cout_r <= cout_r;
            ovf_r  <= ovf_r;
        end
    end

    // Status outputs registered from the next state so they align with state_r.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ADD);
            done_r <= (state_next_s == FIN);
        end
    end

    assign BUSY = busy_r;
    assign DONE = done_r;
    assign S    = s_r;
    assign COUT = cout_r;
    assign OVF  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table plus scoreboard,
// with hand-written back-to-back and reset-abort sequences.
module tb_serial_adder;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CIN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] S;
    logic         COUT;
    logic         OVF;

    always #5 CLK = ~CLK;

    serial_adder #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .S     (S),
        .COUT  (COUT),
        .OVF   (OVF)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    res_t exp_q[$];
    res_t mon_e;
    vec_t vecs[10];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   done_count = 0;
    int   exp_count  = 0;
    int   cycle      = 0;

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Scoreboard: every DONE pops one expected result.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            done_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: DONE with no pending operation (cycle %0d)", cycle);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum",  32'(S),    32'(mon_e.s));
                check("cout", 32'(COUT), 32'(mon_e.cout));
                check("ovf",  32'(OVF),  32'(mon_e.ovf));
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] s, input logic cout, input logic ovf);
        res_t r;
        r.s    = s;
        r.cout = cout;
        r.ovf  = ovf;
        exp_q.push_back(r);
        exp_count++;
    endtask

    // Called at a negedge with the DUT idle; checks BUSY/DONE timing.
    task automatic run_vector(input vec_t v);
        START = 1'b1;
        A     = v.a;
        B     = v.b;
        CIN   = v.cin;
        push_exp(v.s, v.cout, v.ovf);
        @(negedge CLK);
        START = 1'b0;
        A     = W'($urandom_range(255, 0));
        B     = W'($urandom_range(255, 0));
        CIN   = 1'($urandom_range(1, 0));
        for (int k = 0; k < W; k++) begin
            check("busy_in_add", 32'(BUSY), 32'd1);
            check("done_early",  32'(DONE), 32'd0);
            @(negedge CLK);
        end
        check("done_latency", 32'(DONE), 32'd1);
        check("busy_in_fin",  32'(BUSY), 32'd0);
        @(negedge CLK);
        check("done_pulse",   32'(DONE), 32'd0);
    endtask

    task automatic wait_done(output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int k = 0; k < 20; k++) begin
            if (DONE === 1'b1) begin
                ok = 1'b1;
                at = cycle;
                break;
            end
            @(negedge CLK);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_done: DONE not seen within 20 cycles (cycle %0d)", cycle);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        bit ok;

        vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, cout: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'h55, b: 8'hAA, cin: 1'b1, s: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[6] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, cout: 1'b0, ovf: 1'b0};
        vecs[7] = '{a: 8'h40, b: 8'h40, cin: 1'b0, s: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[8] = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, cout: 1'b0, ovf: 1'b0};
        vecs[9] = '{a: 8'h3C, b: 8'hC3, cin: 1'b0, s: 8'hFF, cout: 1'b0, ovf: 1'b0};

        RST   = 1'b1;
        START = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        CIN   = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_s",    32'(S),    32'd0);
        check("rst_cout", 32'(COUT), 32'd0);
        check("rst_ovf",  32'(OVF),  32'd0);

        // First START coincides with the first edge after reset release.
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            run_vector(vecs[i]);
        end

        repeat (3) @(negedge CLK);
        check("hold_s",    32'(S),    32'(vecs[9].s));
        check("hold_cout", 32'(COUT), 32'(vecs[9].cout));
        check("hold_ovf",  32'(OVF),  32'(vecs[9].ovf));
        check("idle_busy", 32'(BUSY), 32'd0);

        // START held through ADD with new operands; re-accepted in the FIN cycle.
        START = 1'b1;
        A     = 8'h0F;
        B     = 8'h01;
        CIN   = 1'b0;
        push_exp(8'h10, 1'b0, 1'b0);
        push_exp(8'h07, 1'b0, 1'b0);
        @(negedge CLK);
        A = 8'h03;
        B = 8'h04;
        wait_done(t1, ok);
        @(negedge CLK);
        START = 1'b0;
        A     = W'($urandom_range(255, 0));
        B     = W'($urandom_range(255, 0));
        check("b2b_busy", 32'(BUSY), 32'd1);
        wait_done(t2, ok);
        check("b2b_gap", 32'(t2 - t1), 32'd9);
        repeat (2) @(negedge CLK);

        // Reset during the 4th ADD cycle, after a result with COUT=1.
        run_vector(vecs[1]);
        START = 1'b1;
        A     = 8'hA5;
        B     = 8'h5A;
        CIN   = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort_busy_before", 32'(BUSY), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_s",    32'(S),    32'd0);
        check("abort_cout", 32'(COUT), 32'd0);
        check("abort_ovf",  32'(OVF),  32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        run_vector(vecs[5]);

        repeat (12) @(negedge CLK);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count",  32'(done_count),   32'(exp_count));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port START  input  1  request to begin an addition; sampled each rising edge.
REQ-005 SHALL have port A  input  WIDTH  first operand; sampled only on the edge where START is accepted.
REQ-006 SHALL have port B  input  WIDTH  second operand; sampled with A.
REQ-007 SHALL have port CIN  input  1  carry-in; sampled with A.
REQ-008 SHALL have port BUSY  output  1  high while an addition is in progress.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse: result valid.
REQ-010 SHALL have port S  output  WIDTH  sum, LSB-first serial result.
REQ-011 SHALL have port COUT  output  1  unsigned carry-out of the MSB.
REQ-012 SHALL have port OVF  output  1  two's-complement overflow flag.

Function
REQ-013 SHALL implement three states: IDLE, ADD, FIN.
REQ-014 IDLE: START=1 accepted -> latch A, B into shift registers, CIN into carry flop, bit counter=0, next state ADD.
REQ-015 ADD: each cycle adds one bit pair (A[i], B[i], carry) through one full adder; sum bit shifted into S from MSB side; carry flop updated; counter incremented.
REQ-016 ADD -> FIN after exactly WIDTH ADD cycles (counter reaches WIDTH-1 on the last bit edge).
REQ-017 FIN: DONE=1 for exactly one cycle; next state IDLE, or ADD if START=1 in that cycle (back-to-back accepted, new operands latched).
REQ-018 Latency: START accepted at edge t0 -> DONE high in cycle after edge t0+WIDTH; BUSY high in cycles after edges t0..t0+WIDTH-1.
REQ-019 BUSY SHALL be 1 in ADD only; 0 in IDLE and FIN.
REQ-020 START while in ADD SHALL be ignored; A, B, CIN changes during ADD SHALL not affect the result.
REQ-021 S, COUT, OVF SHALL be valid from the DONE cycle and held unchanged until the next accepted START's first ADD edge.
REQ-022 S SHALL be intermediate (partially shifted) during ADD; only DONE qualifies it.
REQ-023 COUT = final carry out of bit WIDTH-1; OVF = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-024 Result SHALL equal (A + B + CIN) mod 2^WIDTH, COUT = bit WIDTH of the full sum.

Reset
REQ-025 RST=1 at an edge SHALL force state IDLE, BUSY=0, DONE=0, S=0, COUT=0, OVF=0, counter=0, carry=0.
REQ-026 RST SHALL take priority over START and abort any addition in progress; no DONE follows an aborted operation.
REQ-027 First START SHALL be accepted on the first edge after RST deasserts.

Structure
REQ-028 Shared package SHALL hold state encoding constants (IDLE, ADD, FIN) and default WIDTH.
REQ-029 Counter width SHALL be derived from WIDTH (ceil log2 WIDTH, minimum 1 bit).
REQ-030 One sub-module full_adder (inputs A, B, CI; outputs S, CO) built from two half-adder stages plus OR SHALL be instantiated once.

Verification (WIDTH=8)
REQ-031 A=0x0F, B=0x01, CIN=0, START pulse -> 8 BUSY cycles, DONE next cycle, S=0x10, COUT=0, OVF=0.
REQ-032 A=0xFF, B=0x01, CIN=0 -> S=0x00, COUT=1, OVF=0; A=0x7F, B=0x01 -> S=0x80, COUT=0, OVF=1.
REQ-033 A=0xFF, B=0xFF, CIN=1 -> S=0xFF, COUT=1, OVF=0.
REQ-034 START held high with new A=0x03, B=0x04 mid-ADD -> ignored; original result delivered; START in FIN cycle -> second result (0x07) DONE exactly 9 cycles after the first DONE.
REQ-035 RST asserted at 4th ADD cycle -> next cycle BUSY=0, S=0, COUT=0, no DONE; fresh START then completes normally.
